// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counting timer with one-shot and auto-reload modes.
// Registers: CTRL (EN, MODE, IM), PRESET, and a read-only COUNT; irq = IM & sticky flag.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CNT  = 2'd1,
    INT  = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  state_t      state, state_n;
  logic [3:0]  ctrl, ctrl_n;
  logic [31:0] preset, preset_n;
  logic [31:0] count, count_n;
  logic        flag, flag_n;

  logic        ctrl_wr;
  logic        preset_wr;
  logic        en_off;
  logic        en_clr;
  logic        flag_set;

  assign ctrl_wr   = (addr == ADDR_CTRL) && (byteen != 4'b0000);
  assign preset_wr = (addr == ADDR_PRESET) && (byteen != 4'b0000);
  // Only a write that actually carries byte 0 can turn EN off.
  assign en_off    = ctrl_wr && byteen[0] && !wdata[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ctrl   <= 4'h0;
      preset <= 32'h0;
      count  <= 32'h0;
      flag   <= 1'b0;
    end else begin
      state  <= state_n;
      ctrl   <= ctrl_n;
      preset <= preset_n;
      count  <= count_n;
      flag   <= flag_n;
    end
  end

  // The FSM step looks at pre-write register values; bus writes are layered on top.
  always_comb begin
    state_n  = state;
    count_n  = count;
    flag_n   = flag;
    en_clr   = 1'b0;
    flag_set = 1'b0;

    case (state)
      IDLE: begin
        if (ctrl[0]) begin
          count_n = preset;
          state_n = CNT;
        end
      end
      CNT: begin
        if (!ctrl[0]) begin
          state_n = IDLE;
        end else if (count > 32'd1) begin
          count_n = count - 32'd1;
        end else begin
          count_n  = 32'd0;
          flag_set = 1'b1;
          state_n  = INT;
        end
      end
      INT: begin
        if (ctrl[2:1] == 2'd1) begin
          count_n = preset;
          flag_n  = 1'b0;
          state_n = CNT;
        end else begin
          en_clr  = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    ctrl_n = ctrl;
    if (en_clr) begin
      ctrl_n[0] = 1'b0;
    end
    if (ctrl_wr && byteen[0]) begin
      ctrl_n = wdata[3:0];
    end

    // A CTRL write acknowledges the interrupt, but a flag raised at the same edge survives.
    if (ctrl_wr) begin
      flag_n = 1'b0;
    end
    if (flag_set) begin
      flag_n = 1'b1;
    end

    if (en_off) begin
      state_n = IDLE;
      count_n = count;
    end

    preset_n = preset;
    if (preset_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (byteen[b]) begin
          preset_n[b*8 +: 8] = wdata[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (addr)
      ADDR_CTRL:   rdata = {28'h0, ctrl};
      ADDR_PRESET: rdata = preset;
      ADDR_COUNT:  rdata = count;
      default:     rdata = 32'h0;
    endcase
  end

  assign irq = ctrl[3] & flag;

endmodule
